// File: rtl/life_sequencer_pkg.sv
// Shared definitions for the life sequencer: grid width and the one-hot
// state encoding used by the sequencer FSM.
package life_pkg;

    localparam int GRID_W = 64;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_LOAD  = 5'b00010,
        ST_RUN   = 5'b00100,
        ST_PAUSE = 5'b01000,
        ST_HALT  = 5'b10000
    } state_t;

endpackage

// File: rtl/life_sequencer_if.sv
// Control, seed and generation bus between the life sequencer and its
// controller / evolve datapath.
interface life_sequencer_if #(
    parameter int PERIOD_W = 8,
    parameter int GEN_W    = 16
) ();
    import life_pkg::*;

    logic                start;
    logic                pause;
    logic                step;
    logic                clear;
    logic [GRID_W-1:0]   seed;
    logic [PERIOD_W-1:0] period;
    logic [GRID_W-1:0]   grid_evolve;
    logic [GRID_W-1:0]   grid;
    logic [GEN_W-1:0]    gen_count;
    logic                update;
    logic                running;
    logic                paused;
    logic                halted;
    logic                stable;
    logic                extinct;

    modport master (
        output start, pause, step, clear, seed, period, grid_evolve,
        input  grid, gen_count, update, running, paused, halted, stable, extinct
    );

    modport slave (
        input  start, pause, step, clear, seed, period, grid_evolve,
        output grid, gen_count, update, running, paused, halted, stable, extinct
    );

endinterface

// File: rtl/life_sequencer_gen_timer.sv
// Generation tick timer: counts clocks while running, holds otherwise, and
// flags the cycle in which a generation is due.
module gen_timer #(
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count_q;
    logic [PERIOD_W-1:0] limit;

    // A zero period behaves like one; the >= compare lets a shortened
    // period fire immediately instead of wrapping the counter.
    assign limit = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign tick  = run && (count_q >= limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= tick ? '0 : count_q + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Game-of-life generation sequencer: loads a seed, commits generations from
// an external evolve datapath on a timer or single-step, and halts on a cause.
module life_sequencer
    import life_pkg::*;
#(
    parameter int PERIOD_W = 8,
    parameter int GEN_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    life_sequencer_if.slave bus
);

    state_t            state_q;
    state_t            state_d;

    logic [GRID_W-1:0] grid_q;
    logic [GEN_W-1:0]  gen_q;
    logic              update_q;
    logic              stable_q;
    logic              extinct_q;

    logic              tick;
    logic              timer_clear;
    logic              timer_run;
    logic              load_en;
    logic              commit_en;
    logic              running;
    logic              paused;
    logic              halted;

    logic              evolve_same;
    logic              evolve_empty;
    logic [GEN_W-1:0]  gen_next;
    logic              gen_full;
    logic              halt_cond;

    assign evolve_same  = (bus.grid_evolve == grid_q);
    assign evolve_empty = (bus.grid_evolve == '0);
    assign gen_next     = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
    assign gen_full     = (gen_next == '1);
    assign halt_cond    = evolve_same || evolve_empty || gen_full;

    gen_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_gen_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .run    (timer_run),
        .period (bus.period),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-cycle priority is clear, then pause, then start, then step, then tick.
    always_comb begin
        state_d   = state_q;
        commit_en = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        commit_en = 1'b1;
                        if (halt_cond) state_d = ST_HALT;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) begin
                        if (bus.start) begin
                            state_d = ST_RUN;
                        end else if (bus.step) begin
                            commit_en = 1'b1;
                            if (halt_cond) state_d = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.start) state_d = ST_LOAD;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running     = 1'b0;
        paused      = 1'b0;
        halted      = 1'b0;
        load_en     = 1'b0;
        timer_clear = 1'b0;
        timer_run   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
            end
            ST_LOAD: begin
                timer_clear = 1'b1;
                load_en     = !bus.clear;
            end
            ST_RUN: begin
                running   = 1'b1;
                timer_run = !bus.clear && !bus.pause;
            end
            ST_PAUSE: begin
                paused = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                timer_clear = 1'b1;
            end
        endcase
        if (bus.clear) timer_clear = 1'b1;
    end

    // A stable commit leaves grid and count untouched, so it raises no update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid_q    <= '0;
            gen_q     <= '0;
            update_q  <= 1'b0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (bus.clear) begin
                grid_q    <= '0;
                gen_q     <= '0;
                stable_q  <= 1'b0;
                extinct_q <= 1'b0;
            end else if (load_en) begin
                grid_q    <= bus.seed;
                gen_q     <= '0;
                stable_q  <= 1'b0;
                extinct_q <= 1'b0;
                update_q  <= 1'b1;
            end else if (commit_en) begin
                if (evolve_same) begin
                    stable_q <= 1'b1;
                end else begin
                    grid_q   <= bus.grid_evolve;
                    gen_q    <= gen_next;
                    update_q <= 1'b1;
                    if (evolve_empty) extinct_q <= 1'b1;
                end
            end
        end
    end

    assign bus.grid      = grid_q;
    assign bus.gen_count = gen_q;
    assign bus.update    = update_q;
    assign bus.running   = running;
    assign bus.paused    = paused;
    assign bus.halted    = halted;
    assign bus.stable    = stable_q;
    assign bus.extinct   = extinct_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer: drives a Life model as the evolve
// datapath and scoreboards every update pulse against expected generations.
module tb_life_sequencer;
    import life_pkg::*;

    localparam logic [63:0] BLINK_A = 64'h0000_0000_0000_0070;
    localparam logic [63:0] BLINK_B = 64'h0000_0000_0002_0202;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;

    typedef struct packed {
        logic [63:0] grid;
        logic [15:0] gen;
    } sb_entry_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_compared   = 0;
    int n_mismatched = 0;
    int sb_idx       = 0;

    sb_entry_t exp_q[$];
    sb_entry_t obs_q[$];

    always #5 clk = ~clk;

    life_sequencer_if #(.PERIOD_W(8), .GEN_W(16)) bus  ();
    life_sequencer_if #(.PERIOD_W(8), .GEN_W(4))  bus4 ();

    life_sequencer #(.PERIOD_W(8), .GEN_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    life_sequencer #(.PERIOD_W(8), .GEN_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // Dead-edge Life, except the blinker scenario's two phases swap directly.
    function automatic logic [63:0] evolve_model(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        int rr;
        int cc;
        if (g == BLINK_A) return BLINK_B;
        if (g == BLINK_B) return BLINK_A;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            cnt += int'(g[rr*8+cc]);
                    end
                end
                n[r*8+c] = (cnt == 3) || (cnt == 2 && g[r*8+c]);
            end
        end
        return n;
    endfunction

    assign bus.grid_evolve  = evolve_model(bus.grid);
    assign bus4.grid_evolve = evolve_model(bus4.grid);

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.update === 1'b1)
            obs_q.push_back({bus.grid, bus.gen_count});
    end

    function automatic logic [63:0] flags_main();
        return {58'd0, bus.update, bus.running, bus.paused, bus.halted, bus.stable, bus.extinct};
    endfunction

    function automatic logic [63:0] flags_small();
        return {58'd0, bus4.update, bus4.running, bus4.paused, bus4.halted, bus4.stable, bus4.extinct};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic pa, input logic sp, input logic cl);
        bus.start = st;
        bus.pause = pa;
        bus.step  = sp;
        bus.clear = cl;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_update(input logic [63:0] g, input logic [15:0] gen);
        exp_q.push_back({g, gen});
    endtask

    task automatic drain_scoreboard();
        while (sb_idx < obs_q.size() && sb_idx < exp_q.size()) begin
            check_output("sb_grid", obs_q[sb_idx].grid, exp_q[sb_idx].grid);
            check_output("sb_gen", 64'(obs_q[sb_idx].gen), 64'(exp_q[sb_idx].gen));
            sb_idx++;
        end
    endtask

    initial begin
        int n;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        bus.seed     = '0;
        bus.period   = '0;
        bus4.start   = 1'b0;
        bus4.pause   = 1'b0;
        bus4.step    = 1'b0;
        bus4.clear   = 1'b0;
        bus4.seed    = BLINK_A;
        bus4.period  = '0;

        #2 reset = 1'b0;
        #1;
        check_output("reset_grid", bus.grid, 64'h0);
        check_output("reset_gen", 64'(bus.gen_count), 64'h0);
        check_output("reset_flags", flags_main(), 64'h0);
        check_output("reset_flags_small", flags_small(), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        run_cycles(1);
        check_output("idle_flags", flags_main(), 64'h0);

        // Blinker at period 4: commits on every fourth RUN cycle.
        bus.seed   = BLINK_A;
        bus.period = 8'd4;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expect_update(BLINK_A, 16'd0);
        run_cycles(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("load_flags", flags_main(), 64'h00);
        run_cycles(1);
        check_output("run0_grid", bus.grid, BLINK_A);
        check_output("run0_flags", flags_main(), 64'h30);
        expect_update(BLINK_B, 16'd1);
        run_cycles(3);
        check_output("pre_tick_grid", bus.grid, BLINK_A);
        run_cycles(1);
        check_output("gen1_grid", bus.grid, BLINK_B);
        check_output("gen1_count", 64'(bus.gen_count), 64'd1);
        expect_update(BLINK_A, 16'd2);
        run_cycles(4);
        check_output("gen2_grid", bus.grid, BLINK_A);
        check_output("gen2_count", 64'(bus.gen_count), 64'd2);
        expect_update(BLINK_B, 16'd3);
        run_cycles(4);
        check_output("gen3_grid", bus.grid, BLINK_B);
        check_output("gen3_count", 64'(bus.gen_count), 64'd3);
        drain_scoreboard();

        // Pause exactly on the tick-due cycle, then single-step.
        run_cycles(3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        run_cycles(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("pause_flags", flags_main(), 64'h08);
        check_output("pause_count", 64'(bus.gen_count), 64'd3);
        check_output("pause_grid", bus.grid, BLINK_B);
        run_cycles(2);
        check_output("pause_hold_count", 64'(bus.gen_count), 64'd3);
        expect_update(BLINK_A, 16'd4);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        run_cycles(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("step1_count", 64'(bus.gen_count), 64'd4);
        run_cycles(1);
        check_output("step1_hold_count", 64'(bus.gen_count), 64'd4);
        expect_update(BLINK_B, 16'd5);
        expect_update(BLINK_A, 16'd6);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        run_cycles(2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("step3_count", 64'(bus.gen_count), 64'd6);
        check_output("step3_grid", bus.grid, BLINK_A);
        check_output("step3_flags", flags_main(), 64'h28);

        // Resume: the held counter value is already due, so commit at once.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        run_cycles(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("resume_flags", flags_main(), 64'h10);
        check_output("resume_count", 64'(bus.gen_count), 64'd6);
        expect_update(BLINK_B, 16'd7);
        run_cycles(1);
        check_output("resume_commit_count", 64'(bus.gen_count), 64'd7);
        check_output("resume_commit_grid", bus.grid, BLINK_B);
        drain_scoreboard();

        // Clear beats pause and start.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
        run_cycles(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("clear_grid", bus.grid, 64'h0);
        check_output("clear_count", 64'(bus.gen_count), 64'h0);
        check_output("clear_flags", flags_main(), 64'h0);

        // Shorten the period while the counter is already past the new limit.
        bus.period = 8'd8;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expect_update(BLINK_A, 16'd0);
        run_cycles(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        run_cycles(4);
        check_output("long_period_count", 64'(bus.gen_count), 64'd0);
        bus.period = 8'd2;
        expect_update(BLINK_B, 16'd1);
        run_cycles(1);
        check_output("shortened_commit", 64'(bus.gen_count), 64'd1);
        expect_update(BLINK_A, 16'd2);
        run_cycles(1);
        check_output("period2_wait", 64'(bus.gen_count), 64'd1);
        run_cycles(1);
        check_output("period2_commit", 64'(bus.gen_count), 64'd2);
        #5;
        drain_scoreboard();

        // Asynchronous reset in the middle of RUN.
        reset = 1'b0;
        #1;
        check_output("async_reset_grid", bus.grid, 64'h0);
        check_output("async_reset_count", 64'(bus.gen_count), 64'h0);
        check_output("async_reset_flags", flags_main(), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        run_cycles(1);
        check_output("post_reset_grid", bus.grid, 64'h0);

        // Still life halts on the first commit without an update.
        bus.seed   = BLOCK;
        bus.period = 8'd1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expect_update(BLOCK, 16'd0);
        run_cycles(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        run_cycles(2);
        check_output("block_flags", flags_main(), 64'h06);
        check_output("block_count", 64'(bus.gen_count), 64'd0);
        check_output("block_grid", bus.grid, BLOCK);
        run_cycles(2);
        check_output("block_frozen_grid", bus.grid, BLOCK);

        // Single cell dies: extinct halt straight from HALT via a new load.
        bus.seed   = 64'h1;
        bus.period = 8'd0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expect_update(64'h1, 16'd0);
        expect_update(64'h0, 16'd1);
        run_cycles(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        run_cycles(1);
        check_output("cell_run_flags", flags_main(), 64'h30);
        run_cycles(1);
        check_output("cell_flags", flags_main(), 64'h25);
        check_output("cell_grid", bus.grid, 64'h0);
        check_output("cell_count", 64'(bus.gen_count), 64'd1);
        drain_scoreboard();

        // Narrow counter, period 0: one commit per cycle until all-ones.
        bus4.start = 1'b1;
        run_cycles(1);
        bus4.start = 1'b0;
        n = 0;
        while (bus4.halted !== 1'b1 && n < 40) begin
            run_cycles(1);
            n++;
        end
        check_output("sat_cycles", 64'(n), 64'd16);
        check_output("sat_count", 64'(bus4.gen_count), 64'd15);
        check_output("sat_grid", bus4.grid, BLINK_B);
        check_output("sat_flags", flags_small(), 64'h24);

        run_cycles(2);
        drain_scoreboard();
        check_output("sb_update_count", 64'(obs_q.size()), 64'(exp_q.size()));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
